// File: rtl/if_agc_ctrl_pkg.sv
// Shared radio definitions: AGC state encoding, gain code limits and the
// saturating magnitude helper used by the peak tracker.
package if_radio_pkg;

    localparam int GAIN_W = 3;
    localparam logic [GAIN_W-1:0] GAIN_MAX = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DECIDE  = 2'd2,
        ST_SETTLE  = 2'd3
    } agc_state_t;

    // |x| on 7 bits; -128 has no positive twin so it saturates to 127.
    function automatic logic [6:0] sat_abs(input logic signed [7:0] x);
        logic [7:0] neg;
        neg = 8'(-x);
        if (x == -8'sd128)
            return 7'd127;
        else if (x < 0)
            return neg[6:0];
        else
            return x[6:0];
    endfunction

endpackage

// File: rtl/if_agc_ctrl_if.sv
// Bundle between the AGC and its surroundings: IF samples and SPI
// configuration in, gain select and status out.
interface if_agc_ctrl_if;
    import if_radio_pkg::*;

    logic                    sample_en;
    logic signed [7:0]       if_filt_in;
    logic                    agc_en;
    logic [GAIN_W-1:0]       gain_manual;
    logic [6:0]              thr_hi;
    logic [6:0]              thr_lo;
    logic [GAIN_W-1:0]       gain_out;
    logic                    gain_chg;
    logic [6:0]              peak_out;
    logic                    locked;

    modport master (
        output sample_en, if_filt_in, agc_en, gain_manual, thr_hi, thr_lo,
        input  gain_out, gain_chg, peak_out, locked
    );

    modport slave (
        input  sample_en, if_filt_in, agc_en, gain_manual, thr_hi, thr_lo,
        output gain_out, gain_chg, peak_out, locked
    );

endinterface

// File: rtl/if_agc_ctrl_peak_det.sv
// Window peak tracker: holds the largest saturated magnitude seen since the
// last clear. Clear wins over update.
module if_peak_det
    import if_radio_pkg::*;
(
    input  logic              clk,
    input  logic              RSTb,
    input  logic              clr_i,
    input  logic              upd_i,
    input  logic signed [7:0] sample_i,
    output logic [6:0]        peak_o
);

    logic [6:0] peak_q;
    logic [6:0] mag;

    assign mag    = sat_abs(sample_i);
    assign peak_o = peak_q;

    // Running maximum of qualified sample magnitudes.
    always_ff @(posedge clk) begin
        if (!RSTb)
            peak_q <= '0;
        else if (clr_i)
            peak_q <= '0;
        else if (upd_i && (mag > peak_q))
            peak_q <= mag;
    end

endmodule

// File: rtl/if_agc_ctrl.sv
// IF automatic gain control: measures the peak over a window of samples and
// steps the IF gain down on overload or up after a run of quiet windows.
//
// state      | meaning
// IDLE       | manual gain, AGC parked
// MEASURE    | collect window peak
// DECIDE     | one cycle: publish peak, apply attack/decay
// SETTLE     | discard one window after a gain step
module if_agc_ctrl
    import if_radio_pkg::*;
#(
    parameter int WIN_LOG2 = 10,
    parameter int HOLD_WIN = 4
) (
    input  logic            clk,
    input  logic            RSTb,
    if_agc_ctrl_if.slave    bus
);

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_WIN);

    agc_state_t          state_q;
    logic [WIN_LOG2-1:0] win_cnt_q;
    logic [3:0]          hold_q;
    logic [GAIN_W-1:0]   gain_out_q;
    logic                gain_chg_q;
    logic [6:0]          peak_out_q;
    logic                locked_q;

    logic [6:0]          peak;
    logic                win_done;
    logic [GAIN_W-1:0]   gain_man;
    logic [GAIN_W-1:0]   gain_d;
    logic [3:0]          hold_d;
    logic [3:0]          hold_sat;
    logic                chg_d;

    assign win_done = &win_cnt_q;
    assign gain_man = (bus.gain_manual > GAIN_MAX) ? GAIN_MAX : bus.gain_manual;

    if_peak_det u_peak (
        .clk      (clk),
        .RSTb     (RSTb),
        .clr_i    ((state_q == ST_IDLE) || (state_q == ST_DECIDE)),
        .upd_i    ((state_q == ST_MEASURE) && bus.sample_en && bus.agc_en),
        .sample_i (bus.if_filt_in),
        .peak_o   (peak)
    );

    // Gain decision for DECIDE; attack is checked first so it wins over decay.
    always_comb begin
        gain_d   = gain_out_q;
        hold_d   = '0;
        chg_d    = 1'b0;
        hold_sat = (hold_q >= HOLD_LIM) ? HOLD_LIM : hold_q + 4'd1;
        if (peak >= bus.thr_hi) begin
            if (gain_out_q != '0) begin
                gain_d = gain_out_q - 3'd1;
                chg_d  = 1'b1;
            end
        end else if (peak < bus.thr_lo) begin
            if ((hold_sat == HOLD_LIM) && (gain_out_q < GAIN_MAX)) begin
                gain_d = gain_out_q + 3'd1;
                chg_d  = 1'b1;
            end else begin
                hold_d = hold_sat;
            end
        end
    end

    // Sequencer with registered outputs; disabling the AGC abandons any window.
    always_ff @(posedge clk) begin
        if (!RSTb) begin
            state_q    <= ST_IDLE;
            win_cnt_q  <= '0;
            hold_q     <= '0;
            gain_out_q <= '0;
            gain_chg_q <= 1'b0;
            peak_out_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            gain_chg_q <= 1'b0;
            if (!bus.agc_en) begin
                state_q    <= ST_IDLE;
                win_cnt_q  <= '0;
                hold_q     <= '0;
                gain_out_q <= gain_man;
                locked_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_q   <= ST_MEASURE;
                        win_cnt_q <= '0;
                        hold_q    <= '0;
                    end
                    ST_MEASURE, ST_SETTLE: begin
                        if (bus.sample_en) begin
                            if (win_done) begin
                                win_cnt_q <= '0;
                                state_q   <= (state_q == ST_MEASURE) ? ST_DECIDE : ST_MEASURE;
                            end else begin
                                win_cnt_q <= win_cnt_q + WIN_LOG2'(1);
                            end
                        end
                    end
                    ST_DECIDE: begin
                        peak_out_q <= peak;
                        win_cnt_q  <= '0;
                        hold_q     <= hold_d;
                        gain_out_q <= gain_d;
                        gain_chg_q <= chg_d;
                        locked_q   <= ~chg_d;
                        state_q    <= chg_d ? ST_SETTLE : ST_MEASURE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.gain_out = gain_out_q;
    assign bus.gain_chg = gain_chg_q;
    assign bus.peak_out = peak_out_q;
    assign bus.locked   = locked_q;

endmodule
